// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding and constants for the stopwatch controller
package stopwatch_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2,
    ST_FULL = 2'd3
  } state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int TICK_DIV_DEF = 500000;
endpackage

// File: rtl/stopwatch_ctrl_btn_edge.sv
// btn_edge: two-flop synchronizer plus rising-edge detect for one button level
module btn_edge (
  input  logic Clock,
  input  logic Resetn,
  input  logic btn,
  output logic evt
);
  logic s1, s2, prev;
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) {prev, s2, s1} <= '0;
    else {prev, s2, s1} <= {s2, s1, btn};
  assign evt = s2 & ~prev;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/stop/lap/clear sequencing, tick prescaler and display mux
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int PW = 19
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Start_Stop,
  input  logic       Lap,
  input  logic       Clear_btn,
  input  logic [3:0] BCD3,
  input  logic [3:0] BCD2,
  input  logic [3:0] BCD1,
  input  logic [3:0] BCD0,
  output logic       ENABLE,
  output logic       Clear,
  output logic [3:0] Disp3,
  output logic [3:0] Disp2,
  output logic [3:0] Disp1,
  output logic [3:0] Disp0,
  output logic       Running,
  output logic       Lap_hold,
  output logic       Overflow
);
  logic ev_ss, ev_lap, ev_clr, tick, wrap, all9;
  logic [PW-1:0] presc;
  logic [15:0] bcd, lap_q;
  state_t state;
  btn_edge u_ss  (.Clock(Clock), .Resetn(Resetn), .btn(Start_Stop), .evt(ev_ss));
  btn_edge u_lap (.Clock(Clock), .Resetn(Resetn), .btn(Lap),        .evt(ev_lap));
  btn_edge u_clr (.Clock(Clock), .Resetn(Resetn), .btn(Clear_btn),  .evt(ev_clr));
  assign bcd = {BCD3, BCD2, BCD1, BCD0};
  assign all9 = bcd == {4{BCD_MAX}};
  assign wrap = presc == PW'(TICK_DIV - 1);
  assign Running = state == ST_RUN;
  assign Overflow = state == ST_FULL;
  assign {Disp3, Disp2, Disp1, Disp0} = Lap_hold ? lap_q : bcd;
  // tick is registered at the wrap edge, so ENABLE lands one edge after it
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      state <= ST_IDLE;
      presc <= '0;
      tick <= 1'b0;
      ENABLE <= 1'b0;
      Clear <= 1'b0;
      Lap_hold <= 1'b0;
      lap_q <= '0;
    end else begin
      ENABLE <= tick & ~all9 & ~ev_clr;
      Clear <= ev_clr;
      tick <= ~ev_clr & Running & wrap;
      if (ev_clr) begin
        state <= ST_IDLE;
        presc <= '0;
        Lap_hold <= 1'b0;
      end else begin
        if (Running) presc <= wrap ? '0 : presc + 1'b1;
        if (Running && tick && all9) state <= ST_FULL;
        else if (ev_ss && state != ST_FULL) state <= Running ? ST_STOP : ST_RUN;
        if (ev_lap && !ev_ss) begin
          if (Running && !Lap_hold) begin
            lap_q <= bcd;
            Lap_hold <= 1'b1;
          end else if (Lap_hold && (Running || state == ST_STOP)) Lap_hold <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed checks of the stopwatch controller with a BCD counter model
module tb_stopwatch_ctrl;
  logic Clock, Resetn, Start_Stop, Lap, Clear_btn;
  logic ENABLE, Clear, Running, Lap_hold, Overflow;
  logic [3:0] Disp3, Disp2, Disp1, Disp0;
  logic [15:0] cnt, load_val, disp;
  logic load;
  int checks = 0;
  int errors = 0;

  stopwatch_ctrl #(.TICK_DIV(4), .PW(3)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start_Stop(Start_Stop), .Lap(Lap), .Clear_btn(Clear_btn),
    .BCD3(cnt[15:12]), .BCD2(cnt[11:8]), .BCD1(cnt[7:4]), .BCD0(cnt[3:0]),
    .ENABLE(ENABLE), .Clear(Clear), .Disp3(Disp3), .Disp2(Disp2), .Disp1(Disp1), .Disp0(Disp0),
    .Running(Running), .Lap_hold(Lap_hold), .Overflow(Overflow)
  );

  assign disp = {Disp3, Disp2, Disp1, Disp0};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int d = 0; d < 4; d++)
      if (c) begin
        if (r[d*4+:4] == 4'd9) r[d*4+:4] = 4'd0;
        else begin
          r[d*4+:4] = r[d*4+:4] + 4'd1;
          c = 1'b0;
        end
      end
    return r;
  endfunction

  // four-digit BCD counter the controller drives
  always @(posedge Clock or negedge Resetn)
    if (!Resetn) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (Clear) cnt <= '0;
    else if (ENABLE) cnt <= bcd_inc(cnt);

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clock);
  endtask

  initial begin
    Resetn = 1'b0; Start_Stop = 1'b0; Lap = 1'b0; Clear_btn = 1'b0;
    load = 1'b0; load_val = '0;
    step(3);
    chk1("rst_running", Running, 1'b0);
    chk1("rst_enable", ENABLE, 1'b0);
    chk1("rst_clear", Clear, 1'b0);
    chk1("rst_overflow", Overflow, 1'b0);
    chk1("rst_laphold", Lap_hold, 1'b0);
    chk("rst_disp", disp, 16'h0000);
    Resetn = 1'b1;
    step(2);
    Start_Stop = 1'b1;
    step(2);
    chk1("start_latency", Running, 1'b0);
    Start_Stop = 1'b0;
    step(1);
    chk1("start_running", Running, 1'b1);
    for (int i = 0; i < 14; i++) begin
      chk1("enable_cadence", ENABLE, i == 5 || i == 9 || i == 13);
      step(1);
    end
    chk("count_3", disp, 16'h0003);
    step(1);
    Start_Stop = 1'b1;
    step(2);
    chk1("enable_before_stop", ENABLE, 1'b1);
    chk1("run_before_stop", Running, 1'b1);
    Start_Stop = 1'b0;
    step(1);
    chk1("stopped", Running, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk1("stop_no_enable", ENABLE, 1'b0);
      step(1);
    end
    chk("count_held", disp, 16'h0004);
    Start_Stop = 1'b1;
    step(2);
    chk1("resume_latency", Running, 1'b0);
    Start_Stop = 1'b0;
    step(1);
    chk1("resumed", Running, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk1("resume_enable", ENABLE, i == 3);
      step(1);
    end
    chk("count_5", disp, 16'h0005);
    load_val = 16'h0042; load = 1'b1; Lap = 1'b1;
    step(1);
    load = 1'b0;
    step(1);
    Lap = 1'b0;
    step(1);
    chk1("lap_hold_set", Lap_hold, 1'b1);
    chk("lap_disp", disp, 16'h0042);
    step(8);
    chk1("lap_hold_kept", Lap_hold, 1'b1);
    chk("lap_frozen", disp, 16'h0042);
    Lap = 1'b1;
    step(2);
    Lap = 1'b0;
    step(1);
    chk1("lap_released", Lap_hold, 1'b0);
    chk("lap_live", disp, 16'h0045);
    load_val = 16'h9998; load = 1'b1;
    chk1("pre_full_enable0", ENABLE, 1'b0);
    step(1);
    load = 1'b0;
    chk1("last_enable", ENABLE, 1'b1);
    step(1);
    chk1("pre_full_enable1", ENABLE, 1'b0);
    step(2);
    chk1("pre_full_running", Running, 1'b1);
    step(1);
    chk1("full_overflow", Overflow, 1'b1);
    chk1("full_running", Running, 1'b0);
    chk1("full_no_enable", ENABLE, 1'b0);
    chk("full_disp", disp, 16'h9999);
    Start_Stop = 1'b1;
    step(2);
    Start_Stop = 1'b0;
    step(2);
    chk1("full_ignores_ss", Running, 1'b0);
    chk1("full_sticky", Overflow, 1'b1);
    Clear_btn = 1'b1;
    step(2);
    chk1("clear_latency", Clear, 1'b0);
    Clear_btn = 1'b0;
    step(1);
    chk1("clear_pulse", Clear, 1'b1);
    chk1("clear_overflow", Overflow, 1'b0);
    chk1("clear_running", Running, 1'b0);
    step(1);
    chk1("clear_one_cycle", Clear, 1'b0);
    chk("clear_disp", disp, 16'h0000);
    Start_Stop = 1'b1;
    step(2);
    Start_Stop = 1'b0;
    step(1);
    chk1("restart_running", Running, 1'b1);
    step(2);
    load_val = 16'h0123; load = 1'b1; Clear_btn = 1'b1; Start_Stop = 1'b1;
    step(1);
    load = 1'b0;
    step(1);
    chk1("prio_pre_running", Running, 1'b1);
    chk("prio_pre_disp", disp, 16'h0123);
    Clear_btn = 1'b0; Start_Stop = 1'b0;
    step(1);
    chk1("prio_clear", Clear, 1'b1);
    chk1("prio_running", Running, 1'b0);
    chk1("prio_no_enable", ENABLE, 1'b0);
    step(1);
    chk1("prio_clear_end", Clear, 1'b0);
    chk1("prio_idle", Running, 1'b0);
    chk("prio_disp", disp, 16'h0000);
    Start_Stop = 1'b1;
    step(2);
    Start_Stop = 1'b0;
    step(1);
    chk1("prereset_running", Running, 1'b1);
    Lap = 1'b1;
    step(2);
    Lap = 1'b0;
    step(1);
    chk1("prereset_laphold", Lap_hold, 1'b1);
    #2 Resetn = 1'b0;
    #1;
    chk1("async_running", Running, 1'b0);
    chk1("async_laphold", Lap_hold, 1'b0);
    chk1("async_overflow", Overflow, 1'b0);
    chk1("async_clear", Clear, 1'b0);
    step(1);
    Resetn = 1'b1;
    step(1);
    Start_Stop = 1'b1;
    step(2);
    Start_Stop = 1'b0;
    step(1);
    chk1("post_reset_running", Running, 1'b1);
    for (int i = 0; i < 6; i++) begin
      chk1("post_reset_enable", ENABLE, i == 5);
      step(1);
    end
    chk("post_reset_count", disp, 16'h0001);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Sequencing controller for the 4-digit BCD counter; together they form the board-level stopwatch.
- Turns debounced push-button levels into Start/Stop, Lap and Clear actions.
- Drives the counter's ENABLE (prescaled tick) and Clear (one-cycle pulse).
- Saturates at 9999, and muxes live or lap-frozen digits to the 7-segment decoders.

Parameters:
- TICK_DIV, 500000, Clock cycles per count tick (50 MHz -> 0.01 s); legal range >= 2.
- PW, 19, prescaler width; must satisfy 2**PW >= TICK_DIV.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Start_Stop  in  1  debounced button level; rising edge toggles run/stop.
- Lap  in  1  debounced button level; rising edge toggles lap freeze.
- Clear_btn  in  1  debounced button level; rising edge clears everything.
- BCD3..BCD0  in  4 each  live counter digits fed back from the counter.
- ENABLE  out  1  one-cycle count-enable pulse to the counter.
- Clear  out  1  one-cycle synchronous clear pulse to the counter.
- Disp3..Disp0  out  4 each  digits to the display decoders.
- Running  out  1  high in RUN.
- Lap_hold  out  1  high while the display is frozen.
- Overflow  out  1  sticky; high in FULL.

Behaviour:
- Reset (Resetn=0, asynchronous): state=IDLE, prescaler=0, ENABLE=0, Clear=0, Lap_hold=0, Overflow=0, lap registers=0, sync/edge flops=0. Disp shows the live BCD inputs.
- Button front end: each button has a 2-flop synchronizer plus a previous-value flop; event = sync2 & ~prev.
  - A button first sampled high at edge k acts at edge k+2.
  - Holding a button produces exactly one event.
- Event priority within one cycle: Clear_btn > Start_Stop > Lap. A lower-priority event in the same cycle is discarded.
- States: IDLE, RUN, STOP, FULL (registered FSM).
  - IDLE: Start_Stop -> RUN, prescaler=0.
  - RUN: Start_Stop -> STOP.
  - RUN: tick when count==9999 -> FULL, Overflow=1.
  - STOP: Start_Stop -> RUN; prescaler keeps its held value.
  - FULL: Start_Stop and Lap ignored.
  - Any state: Clear_btn -> IDLE. On that edge: Clear=1 for exactly one cycle, prescaler=0, Lap_hold=0, Overflow=0. The counter reads 0000 one edge later.
- Prescaler:
  - Increments only in RUN; holds in IDLE/STOP/FULL.
  - At TICK_DIV-1 it wraps to 0 and raises tick.
- ENABLE: registered, high for exactly the one cycle following the tick.
  - Suppressed when BCD3..0 == 9,9,9,9 at tick time; the counter therefore never wraps.
  - Never asserted in the same cycle as Clear.
  - First ENABLE after IDLE->RUN occurs TICK_DIV+1 edges after the transition edge.
- Lap:
  - In RUN with Lap_hold=0: capture BCD3..0 into lap registers, Lap_hold=1.
  - In RUN or STOP with Lap_hold=1: Lap_hold=0.
  - In STOP with Lap_hold=0, or in IDLE: no effect.
- Disp = lap registers when Lap_hold=1, else the BCD inputs (combinational mux).
- Running = (state==RUN). Overflow = (state==FULL).
- Reset mid-run: all state asynchronously returns to reset values; Clear is not pulsed. The counter's own Reset handles the digits.

Decomposition:
- Shared package stopwatch_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_STOP=2'd2, ST_FULL=2'd3;
  - BCD_MAX=4'd9;
  - the default TICK_DIV.
- One natural sub-module: btn_edge (2-flop synchronizer + rising-edge detect, one instance per button).

Test Plan:
- TICK_DIV=4. Reset, pulse Start_Stop -> Running=1 two edges later; ENABLE single-cycle every 4 cycles; counter reaches 0003 after 3 pulses.
- Running, press Start_Stop -> Running=0, ENABLE stays 0. Press again -> next ENABLE exactly after the remaining prescaler cycles, not a fresh 4.
- Count at 0042, press Lap -> Lap_hold=1, Disp=0042 while BCD keeps advancing. Lap again -> Disp tracks live count.
- Force counter to 9998, run -> ENABLE once (9999). Next tick: no ENABLE, Overflow=1, Running=0; Start_Stop ignored.
- Clear_btn and Start_Stop rise in the same cycle while in RUN -> IDLE, Clear high exactly 1 cycle, counter=0000, Overflow=0, Running=0.
- Drop Resetn mid-run between clock edges -> outputs reset immediately without waiting for a clock edge. After release, a Start_Stop press resumes normal operation.
